// File: rtl/ttag_pkg.sv
// Shared types and widths for the time-tag sequencer.
package ttag_pkg;

  localparam int CNT_W = 27;
  localparam int SEC_W = 4;
  localparam int TAG_W = CNT_W + SEC_W;

  typedef enum logic [0:0] {
    WAIT_PPS = 1'b0,
    ARMED    = 1'b1
  } state_t;

endpackage

// File: rtl/ttag_fifo.sv
// Tag FIFO: power-of-two depth circular buffer, head presented from storage.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ttag_fifo import ttag_pkg::*; #(
  parameter int WIDTH = TAG_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head_data = mem_r[rd_ptr_r];

  // storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/time_tag_sequencer.sv
// PPS-disciplined time tagger: manages an external free-running counter and
// queues {second index, count} tags on trigger edges. Optional macro
// TTAG_INPUT_SYNC_EN adds 2-flop synchronizers on pps/trig.
module time_tag_sequencer import ttag_pkg::*; #(
  parameter int CNT_W      = ttag_pkg::CNT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   pps,
  input  logic                   trig,
  input  logic [CNT_W-1:0]       cnt_val,
  output logic                   cnt_clr,
  output logic [CNT_W-1:0]       pps_period,
  output logic [CNT_W+SEC_W-1:0] tag_data,
  output logic                   tag_valid,
  input  logic                   tag_ready,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic                   pps_lost
);

  logic pps_in_s;
  logic trig_in_s;

`ifdef TTAG_INPUT_SYNC_EN
  logic [1:0] pps_sync_r;
  logic [1:0] trig_sync_r;

  // pins may come from outside this clock domain
  always_ff @(posedge clk) begin
    if (res) begin
      pps_sync_r  <= 2'b00;
      trig_sync_r <= 2'b00;
    end else begin
      pps_sync_r  <= {pps_sync_r[0], pps};
      trig_sync_r <= {trig_sync_r[0], trig};
    end
  end

  assign pps_in_s  = pps_sync_r[1];
  assign trig_in_s = trig_sync_r[1];
`else
  assign pps_in_s  = pps;
  assign trig_in_s = trig;
`endif

  logic             pps_q_r, pps_prev_r, trig_q_r, trig_prev_r;
  logic             pps_edge_s, trig_edge_s;
  state_t           state_r, state_nxt_s;
  logic [SEC_W-1:0] sec_idx_r, sec_nxt_s;
  logic [CNT_W-1:0] pps_period_r, period_nxt_s;
  logic             pps_lost_r, lost_nxt_s;
  logic             cnt_clr_r, ovf_r;
  logic             push_s, pop_s, drop_s;
  logic             fifo_full_s, fifo_empty_s;

  // edge-detect registers
  always_ff @(posedge clk) begin
    if (res) begin
      pps_q_r     <= 1'b0;
      pps_prev_r  <= 1'b0;
      trig_q_r    <= 1'b0;
      trig_prev_r <= 1'b0;
    end else begin
      pps_q_r     <= pps_in_s;
      pps_prev_r  <= pps_q_r;
      trig_q_r    <= trig_in_s;
      trig_prev_r <= trig_q_r;
    end
  end

  assign pps_edge_s  = pps_q_r & ~pps_prev_r;
  assign trig_edge_s = trig_q_r & ~trig_prev_r;

  // next state; a coincident trig is tagged with the pre-PPS sec_idx and count
  always_comb begin
    state_nxt_s  = state_r;
    sec_nxt_s    = sec_idx_r;
    period_nxt_s = pps_period_r;
    lost_nxt_s   = pps_lost_r;
    push_s       = 1'b0;
    case (state_r)
      WAIT_PPS: begin
        if (pps_edge_s) begin
          state_nxt_s = ARMED;
          sec_nxt_s   = {SEC_W{1'b0}};
          lost_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = WAIT_PPS;
        end
      end
      ARMED: begin
        push_s = trig_edge_s;
        if (pps_edge_s) begin
          period_nxt_s = cnt_val;
          sec_nxt_s    = sec_idx_r + SEC_W'(1);
        end else if (&cnt_val) begin
          lost_nxt_s  = 1'b1;
          state_nxt_s = WAIT_PPS;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      default: begin
        state_nxt_s = WAIT_PPS;
      end
    endcase
  end

  assign pop_s  = tag_valid & tag_ready;
  assign drop_s = push_s & fifo_full_s & ~pop_s;

  // control registers; ovf set wins over its clear
  always_ff @(posedge clk) begin
    if (res) begin
      state_r      <= WAIT_PPS;
      sec_idx_r    <= {SEC_W{1'b0}};
      pps_period_r <= {CNT_W{1'b0}};
      pps_lost_r   <= 1'b0;
      cnt_clr_r    <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      sec_idx_r    <= sec_nxt_s;
      pps_period_r <= period_nxt_s;
      pps_lost_r   <= lost_nxt_s;
      cnt_clr_r    <= pps_edge_s;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  ttag_fifo #(
    .WIDTH (CNT_W + SEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .res       (res),
    .push      (push_s),
    .push_data ({sec_idx_r, cnt_val}),
    .pop       (pop_s),
    .head_data (tag_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign tag_valid  = ~fifo_empty_s;
  assign cnt_clr    = cnt_clr_r;
  assign pps_period = pps_period_r;
  assign ovf        = ovf_r;
  assign pps_lost   = pps_lost_r;

endmodule

// File: doc/time_tag_sequencer.md
TIME_TAG_SEQUENCER -- requirements
Module: time_tag_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 27, width of the managed free-running counter.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of trigger tags buffered (power of two, >= 2).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port res  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port pps  in  1  pulse-per-second input, rising-edge significant.
REQ-006 SHALL have port trig  in  1  event trigger input, rising-edge significant.
REQ-007 SHALL have port cnt_val  in  CNT_W  current value of the managed counter.
REQ-008 SHALL have port cnt_clr  out  1  clear strobe to the managed counter's reset.
REQ-009 SHALL have port pps_period  out  CNT_W  counter value captured at the last PPS.
REQ-010 SHALL have port tag_data  out  CNT_W+4  {sec_idx[3:0], count} at the FIFO head.
REQ-011 SHALL have port tag_valid  out  1  FIFO non-empty.
REQ-012 SHALL have port tag_ready  in  1  consumer accepts the head when it is high together with tag_valid.
REQ-013 SHALL have port ovf  out  1  sticky: a trigger was dropped.
REQ-014 SHALL have port ovf_clr  in  1  clears ovf.
REQ-015 SHALL have port pps_lost  out  1  sticky: counter reached all-ones without a PPS.

Function
REQ-016 SHALL register pps and trig once and detect a rising edge as the current sample high and the previous sample low; the detect cycle is N.
REQ-017 SHALL implement the states WAIT_PPS and ARMED; reset enters WAIT_PPS.
REQ-018 In WAIT_PPS, on a PPS edge, the block SHALL drive cnt_clr high for cycle N+1 only, set sec_idx=0, clear pps_lost, and go to ARMED; pps_period is unchanged.
REQ-019 In ARMED, on a PPS edge, the block SHALL load pps_period with cnt_val sampled at cycle N, drive cnt_clr for cycle N+1 only, and increment sec_idx (15 wraps to 0).
REQ-020 In ARMED, on a trig edge, the block SHALL push {sec_idx, cnt_val} sampled at cycle N, with tag_valid high no later than N+1.
REQ-021 Trig edges in WAIT_PPS SHALL be ignored; they are not pushed and do not set ovf.
REQ-022 When PPS and trig edges coincide, the tag SHALL use the pre-clear cnt_val and the old sec_idx.
REQ-023 A pop SHALL occur when tag_valid and tag_ready are both high; tag_data SHALL then present the next entry in the next cycle.
REQ-024 A push to a full FIFO without a same-cycle pop SHALL be dropped and SHALL set ovf; with a same-cycle pop it SHALL be accepted.
REQ-025 ovf SHALL clear on ovf_clr unless a drop occurs in the same cycle, in which case ovf stays high.
REQ-026 In ARMED, when cnt_val equals all-ones, the block SHALL set pps_lost and return to WAIT_PPS; the FIFO contents SHALL be kept.

Reset
REQ-027 Reset SHALL produce: state WAIT_PPS, cnt_clr=0, pps_period=0, sec_idx=0, FIFO empty, tag_valid=0, tag_data=0, ovf=0, pps_lost=0, edge registers=0.
REQ-028 Reset mid-operation SHALL discard buffered tags and abort any pending cnt_clr.

Configuration
REQ-029 With macro TTAG_INPUT_SYNC_EN defined, pps and trig SHALL pass through a 2-flop synchronizer ahead of edge detection, adding 2 cycles of latency from pin to detect.
REQ-030 Without TTAG_INPUT_SYNC_EN, the inputs SHALL be treated as synchronous to clk, and the REQ-016 timing SHALL apply unchanged.

Structure
REQ-031 Package ttag_pkg SHALL hold CNT_W, SEC_W=4, TAG_W=CNT_W+SEC_W, and the state enumeration.
REQ-032 The FIFO SHALL be a sub-module ttag_fifo with push/pop/full/empty, ovf logic outside it.

Verification
REQ-033 The bench SHALL cover: res, then PPS edge -> cnt_clr high exactly 1 cycle, state ARMED, pps_period=0.
REQ-034 The bench SHALL cover: second PPS with cnt_val=1000 at detect -> pps_period=1000, sec_idx=1, cnt_clr 1 cycle.
REQ-035 The bench SHALL cover: 5 trig edges, tag_ready=0, FIFO_DEPTH=4 -> 4 tags held, ovf=1, then ovf_clr -> ovf=0.
REQ-036 The bench SHALL cover: PPS and trig in the same cycle with cnt_val=500 and sec_idx=3 -> tag {3,500}, then pps_period=500.
REQ-037 The bench SHALL cover: no PPS until cnt_val=2^27-1 -> pps_lost=1, state WAIT_PPS, trig ignored; next PPS -> pps_lost=0.
REQ-038 The bench SHALL cover: full FIFO with simultaneous push and pop -> no drop, ovf stays 0, order preserved.
